// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the core load/store port and a
// word-addressed synchronous RAM with a fixed read latency. It also decodes one
// memory-mapped output register and flags illegal accesses.
//
// Ports
//   clk_i              clock, all state on the rising edge
//   rst_i              synchronous reset, active high
//   read_i / write_i   core load / store request (level, held while stall_o high)
//   dir_dmem_i         word address from the core
//   data_write_dmem_i  store data from the core
//   data_read_dmem_o   load data to the core
//   stall_o            core holds PC and request while high
//   err_o              sticky illegal-access flag (cleared by reset only)
//   mem_addr_o         RAM word address
//   mem_wdata_o        RAM write data
//   mem_we_o           RAM write strobe, one-cycle pulse
//   mem_re_o           RAM read strobe, one-cycle pulse
//   mem_rdata_i        RAM read data, valid WAIT_STATES cycles after mem_re_o
//   io_out_o           memory-mapped output register
module dmem_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       dir_dmem_i,
    input  logic [31:0]       data_write_dmem_i,
    output logic [31:0]       data_read_dmem_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       io_out_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Counter load value; it also marks the first ACCESS cycle, where the
    // strobe is issued.
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              load_q, load_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       io_q, io_d;
    logic              err_q, err_d;

    // Address decode; only acted on in IDLE.
    logic req, both, hit_io, hit_ram;
    logic acc_bad, acc_io, acc_ram;

    assign req     = read_i | write_i;
    assign both    = read_i & write_i;
    assign hit_io  = (dir_dmem_i == IO_ADDR);
    assign hit_ram = ((dir_dmem_i >> ADDR_W) == 32'd0);
    assign acc_bad = req & (both | (~hit_io & ~hit_ram));
    assign acc_io  = req & ~both & hit_io;
    // IO decode wins should IO_ADDR ever be placed inside the RAM range.
    assign acc_ram = req & ~both & hit_ram & ~hit_io;

    logic        stall_c, we_c, re_c;
    logic [31:0] drd_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        rdata_d = rdata_q;
        io_d    = io_q;
        err_d   = err_q;
        stall_c = 1'b0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        drd_c   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (acc_bad) begin
                    err_d = 1'b1;
                    drd_c = 32'd0;
                end else if (acc_io) begin
                    if (write_i) io_d = data_write_dmem_i;
                    if (read_i)  drd_c = io_q;
                end else if (acc_ram) begin
                    stall_c = 1'b1;
                    addr_d  = dir_dmem_i[ADDR_W-1:0];
                    wdata_d = data_write_dmem_i;
                    load_d  = read_i;
                    cnt_d   = WS_INIT;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall_c = 1'b1;
                if (cnt_q == WS_INIT) begin
                    re_c = load_q;
                    we_c = ~load_q;
                end
                if (cnt_q == 4'd0) begin
                    // Stores take the same path but have nothing to capture.
                    if (load_q) rdata_d = mem_rdata_i;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // The core still presents the finished request here; drop it.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            load_q  <= 1'b0;
            rdata_q <= 32'd0;
            io_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
            io_q    <= io_d;
            err_q   <= err_d;
        end
    end

    assign stall_o          = stall_c & ~rst_i;
    assign mem_we_o         = we_c & ~rst_i;
    assign mem_re_o         = re_c & ~rst_i;
    assign data_read_dmem_o = drd_c;
    assign err_o            = err_q;
    assign io_out_o         = io_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;

endmodule
